// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported 16-bit memory between the
// instruction-fetch port and the data (load/store) port. Data has strict
// priority in IDLE; an access in flight is never pre-empted. Byte loads are
// lane-selected and sign/zero-extended here. Bad data/fetch requests are
// answered without touching memory and set the sticky err flag.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | sample requests, launch memory cycle or go straight to RESP
// S_FETCH | fetch cycle outstanding, waiting for mem_ack or timeout
// S_DATA  | data cycle outstanding, waiting for mem_ack or timeout
// S_RESP  | one-cycle ack pulse to the requester, requests not sampled
module mem_port_arbiter #(
   parameter int AW      = 16,
   parameter int TIMEOUT = 15
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          if_req,
   input  logic [AW-1:0] if_addr,
   output logic [15:0]   if_rdata,
   output logic          if_ack,
   input  logic          dm_rd,
   input  logic          dm_wr,
   input  logic [AW-1:0] dm_addr,
   input  logic [15:0]   dm_wdata,
   input  logic [1:0]    dm_size,
   output logic [15:0]   dm_rdata,
   output logic          dm_ack,
   output logic          mem_req,
   output logic          mem_we,
   output logic [AW-2:0] mem_addr,
   output logic [1:0]    mem_be,
   output logic [15:0]   mem_wdata,
   input  logic [15:0]   mem_rdata,
   input  logic          mem_ack,
   output logic          stall_if,
   output logic          stall_mem,
   output logic          err
);

   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DATA, S_RESP} state_t;

   // Down-counter reload: reaching zero means TIMEOUT cycles spent waiting.
   localparam logic [7:0] C_TC_LOAD = 8'(TIMEOUT - 1);

   state_t      r_state;
   logic [7:0]  r_cnt;
   logic [1:0]  r_size;

   logic        w_dm_any;
   logic        w_dm_bad;
   logic [7:0]  w_byte;
   logic [15:0] w_load;

   assign w_dm_any  = dm_rd | dm_wr;
   assign w_dm_bad  = (dm_rd & dm_wr) | (dm_size == 2'b11) |
                      ((dm_size == 2'b00) & dm_addr[0]);
   assign stall_if  = if_req & ~if_ack;
   assign stall_mem = w_dm_any & ~dm_ack;

   // Load result formatting: byte lane follows the registered byte enable.
   always_comb begin
      w_byte = mem_be[1] ? mem_rdata[15:8] : mem_rdata[7:0];
      w_load = mem_rdata;
      if (r_size == 2'b10)
         w_load = {{8{w_byte[7]}}, w_byte};
      else if (r_size == 2'b01)
         w_load = {8'h00, w_byte};
   end

   // Arbitration FSM with registered memory-side and requester-side outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_cnt     <= '0;
         r_size    <= '0;
         if_rdata  <= '0;
         dm_rdata  <= '0;
         if_ack    <= 1'b0;
         dm_ack    <= 1'b0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_be    <= '0;
         mem_wdata <= '0;
         err       <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_dm_any) begin
                  r_size <= dm_size;
                  if (w_dm_bad) begin
                     r_state  <= S_RESP;
                     dm_ack   <= 1'b1;
                     dm_rdata <= '0;
                     err      <= 1'b1;
                  end else begin
                     r_state  <= S_DATA;
                     r_cnt    <= C_TC_LOAD;
                     mem_req  <= 1'b1;
                     mem_we   <= dm_wr;
                     mem_addr <= dm_addr[AW-1:1];
                     if (dm_size == 2'b00) begin
                        mem_be    <= 2'b11;
                        mem_wdata <= dm_wdata;
                     end else begin
                        mem_be    <= dm_addr[0] ? 2'b10 : 2'b01;
                        mem_wdata <= {dm_wdata[7:0], dm_wdata[7:0]};
                     end
                  end
               end else if (if_req) begin
                  if (if_addr[0]) begin
                     r_state  <= S_RESP;
                     if_ack   <= 1'b1;
                     if_rdata <= '0;
                     err      <= 1'b1;
                  end else begin
                     r_state  <= S_FETCH;
                     r_cnt    <= C_TC_LOAD;
                     mem_req  <= 1'b1;
                     mem_we   <= 1'b0;
                     mem_addr <= if_addr[AW-1:1];
                     mem_be   <= 2'b11;
                  end
               end
            end
            S_FETCH, S_DATA: begin
               if (mem_ack || r_cnt == 8'd0) begin
                  r_state <= S_RESP;
                  mem_req <= 1'b0;
                  mem_we  <= 1'b0;
                  if (!mem_ack)
                     err <= 1'b1;
                  if (r_state == S_DATA) begin
                     dm_ack   <= 1'b1;
                     dm_rdata <= (mem_ack && !mem_we) ? w_load : 16'h0000;
                  end else begin
                     if_ack   <= 1'b1;
                     if_rdata <= mem_ack ? mem_rdata : 16'h0000;
                  end
               end else begin
                  r_cnt <= r_cnt - 8'd1;
               end
            end
            S_RESP: begin
               r_state <= S_IDLE;
               if_ack  <= 1'b0;
               dm_ack  <= 1'b0;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: behavioural memory with programmable latency,
// table of single accesses, scoreboard of expected acks, and hand sequences
// for priority, timeout, reset abort and rejected requests.
module tb_mem_port_arbiter;

   localparam int AW = 16;
   localparam int TO = 15;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          if_req;
   logic [AW-1:0] if_addr;
   logic [15:0]   if_rdata;
   logic          if_ack;
   logic          dm_rd, dm_wr;
   logic [AW-1:0] dm_addr;
   logic [15:0]   dm_wdata;
   logic [1:0]    dm_size;
   logic [15:0]   dm_rdata;
   logic          dm_ack;
   logic          mem_req, mem_we;
   logic [AW-2:0] mem_addr;
   logic [1:0]    mem_be;
   logic [15:0]   mem_wdata;
   logic [15:0]   mem_rdata;
   logic          mem_ack;
   logic          stall_if, stall_mem, err;

   mem_port_arbiter #(.AW(AW), .TIMEOUT(TO)) dut (
      .clk(clk), .rst_n(rst_n),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
      .dm_rd(dm_rd), .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .dm_size(dm_size), .dm_rdata(dm_rdata), .dm_ack(dm_ack),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
      .stall_if(stall_if), .stall_mem(stall_mem), .err(err)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   // ---------------- memory model ----------------
   int          mem_lat = 1;
   bit          mem_en  = 1'b1;
   int          pre_seq = 0;
   int          pre_idx = 0;
   logic [15:0] pre_val = '0;

   initial begin
      logic [15:0] mem_arr [0:255];
      int wait_cnt;
      int pre_done;
      for (int i = 0; i < 256; i++) mem_arr[i] = '0;
      wait_cnt  = 0;
      pre_done  = 0;
      mem_ack   = 1'b0;
      mem_rdata = '0;
      forever begin
         @(negedge clk);
         if (pre_seq != pre_done) begin
            mem_arr[pre_idx] = pre_val;
            pre_done = pre_seq;
         end
         if (mem_req && mem_en && !mem_ack) begin
            if (wait_cnt + 1 >= mem_lat) begin
               mem_ack   = 1'b1;
               mem_rdata = mem_arr[mem_addr[7:0]];
               if (mem_we) begin
                  if (mem_be[0]) mem_arr[mem_addr[7:0]][7:0]  = mem_wdata[7:0];
                  if (mem_be[1]) mem_arr[mem_addr[7:0]][15:8] = mem_wdata[15:8];
               end
            end else begin
               wait_cnt++;
            end
         end else begin
            mem_ack  = 1'b0;
            wait_cnt = 0;
         end
      end
   end

   // ---------------- scoreboard ----------------
   typedef struct {
      bit          is_data;
      logic [15:0] rdata;
      bit          cmp_rd;
      bit          err;
   } sb_t;
   sb_t sb_q[$];

   always @(negedge clk) begin
      if (rst_n && (if_ack || dm_ack)) begin
         if (sb_q.size() == 0) begin
            chk("sb_unexpected_ack", {if_ack, dm_ack}, 0);
         end else begin
            sb_t e;
            e = sb_q.pop_front();
            chk("sb_ack_port", {if_ack, dm_ack}, e.is_data ? 2'b01 : 2'b10);
            if (e.cmp_rd)
               chk("sb_rdata", e.is_data ? dm_rdata : if_rdata, e.rdata);
            chk("sb_err", err, e.err);
         end
      end
   end

   // ---------------- vector table ----------------
   // kind: 0 fetch, 1 load, 2 store, 3 load+store (illegal)
   typedef struct {
      int          kind;
      logic [15:0] addr;
      logic [15:0] wdata;
      logic [1:0]  size;
      int          lat;
      bit          pre;
      logic [15:0] pre_data;
      bit          bad;
      logic [1:0]  exp_be;
      logic [15:0] exp_wdata;
      logic [15:0] exp_rdata;
      bit          exp_err;
   } vec_t;

   localparam int N_OK  = 10;
   localparam int N_VEC = 15;
   vec_t vecs [N_VEC];

   task automatic drop_all();
      if_req = 1'b0; dm_rd = 1'b0; dm_wr = 1'b0;
   endtask

   task automatic run_vec(input int idx, input vec_t v);
      int  n;
      bit  seen_req, done;
      sb_t e;
      @(posedge clk); #1;
      mem_lat = v.lat;
      if (v.pre) begin
         pre_idx = int'(v.addr[8:1]);
         pre_val = v.pre_data;
         pre_seq++;
      end
      if_addr  = v.addr;
      dm_addr  = v.addr;
      dm_wdata = v.wdata;
      dm_size  = v.size;
      if_req   = (v.kind == 0);
      dm_rd    = (v.kind == 1) || (v.kind == 3);
      dm_wr    = (v.kind == 2) || (v.kind == 3);
      e.is_data = (v.kind != 0);
      e.rdata   = v.exp_rdata;
      e.cmp_rd  = (v.kind != 2);
      e.err     = v.exp_err;
      sb_q.push_back(e);
      n = 0; seen_req = 1'b0; done = 1'b0;
      while (!done && n < 40) begin
         @(negedge clk);
         if (mem_req && !seen_req) begin
            seen_req = 1'b1;
            if (v.bad) begin
               chk($sformatf("v%0d_no_mem_req", idx), mem_req, 0);
            end else begin
               chk($sformatf("v%0d_mem_addr", idx), mem_addr, v.addr[15:1]);
               chk($sformatf("v%0d_mem_be", idx), mem_be, v.exp_be);
               chk($sformatf("v%0d_mem_we", idx), mem_we, (v.kind == 2));
               if (v.kind == 2)
                  chk($sformatf("v%0d_mem_wdata", idx), mem_wdata, v.exp_wdata);
            end
         end
         if (if_ack || dm_ack) begin
            done = 1'b1;
            chk($sformatf("v%0d_stall_clear", idx), {stall_if, stall_mem}, 0);
         end else begin
            chk($sformatf("v%0d_stall", idx), {stall_if, stall_mem},
                (v.kind == 0) ? 2'b10 : 2'b01);
            @(posedge clk);
            n++;
         end
      end
      chk($sformatf("v%0d_ack_seen", idx), done, 1);
      chk($sformatf("v%0d_latency", idx), n, v.bad ? 1 : 1 + v.lat);
      chk($sformatf("v%0d_mem_req_seen", idx), seen_req, !v.bad);
      @(posedge clk); #1;
      drop_all();
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int n, hi, ack_n, phase;
      bit done, drop_dm;
      sb_t e;

      vecs[0]  = '{0, 16'h0010, 16'h0000, 2'b00, 1, 1, 16'hA5C3, 0, 2'b11, 16'h0000, 16'hA5C3, 0};
      vecs[1]  = '{1, 16'h0021, 16'h0000, 2'b10, 1, 1, 16'h80FF, 0, 2'b10, 16'h0000, 16'hFF80, 0};
      vecs[2]  = '{1, 16'h0021, 16'h0000, 2'b01, 2, 1, 16'h80FF, 0, 2'b10, 16'h0000, 16'h0080, 0};
      vecs[3]  = '{2, 16'h0007, 16'h00AB, 2'b01, 1, 0, 16'h0000, 0, 2'b10, 16'hABAB, 16'h0000, 0};
      vecs[4]  = '{1, 16'h0006, 16'h0000, 2'b00, 3, 0, 16'h0000, 0, 2'b11, 16'h0000, 16'hAB00, 0};
      vecs[5]  = '{1, 16'h0020, 16'h0000, 2'b10, 1, 1, 16'h80FF, 0, 2'b01, 16'h0000, 16'hFFFF, 0};
      vecs[6]  = '{2, 16'h0004, 16'h5A5A, 2'b00, 2, 0, 16'h0000, 0, 2'b11, 16'h5A5A, 16'h0000, 0};
      vecs[7]  = '{0, 16'h0100, 16'h0000, 2'b00, 2, 1, 16'hBEEF, 0, 2'b11, 16'h0000, 16'hBEEF, 0};
      vecs[8]  = '{1, 16'h0031, 16'h0000, 2'b01, 1, 1, 16'h7F12, 0, 2'b10, 16'h0000, 16'h007F, 0};
      vecs[9]  = '{1, 16'h0031, 16'h0000, 2'b10, 1, 1, 16'h7F12, 0, 2'b10, 16'h0000, 16'h007F, 0};
      vecs[10] = '{1, 16'h0003, 16'h0000, 2'b00, 1, 0, 16'h0000, 1, 2'b00, 16'h0000, 16'h0000, 1};
      vecs[11] = '{1, 16'h0010, 16'h0000, 2'b11, 1, 0, 16'h0000, 1, 2'b00, 16'h0000, 16'h0000, 1};
      vecs[12] = '{3, 16'h0010, 16'h5555, 2'b00, 1, 0, 16'h0000, 1, 2'b00, 16'h0000, 16'h0000, 1};
      vecs[13] = '{0, 16'h0011, 16'h0000, 2'b00, 1, 0, 16'h0000, 1, 2'b00, 16'h0000, 16'h0000, 1};
      vecs[14] = '{0, 16'h0010, 16'h0000, 2'b00, 1, 0, 16'h0000, 0, 2'b11, 16'h0000, 16'hA5C3, 1};

      rst_n = 1'b0;
      drop_all();
      if_addr = '0; dm_addr = '0; dm_wdata = '0; dm_size = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_outputs", {if_ack, dm_ack, mem_req, mem_we, mem_be, err}, 0);
      chk("rst_data", {if_rdata, dm_rdata}, 0);
      chk("rst_mem_bus", {mem_addr, mem_wdata}, 0);
      rst_n = 1'b1;

      for (int i = 0; i < N_OK; i++) run_vec(i, vecs[i]);

      // Simultaneous store and fetch: store wins, fetch follows after RESP+IDLE.
      @(posedge clk); #1;
      mem_lat = 1;
      if_req = 1'b1; if_addr = 16'h0004;
      dm_wr = 1'b1; dm_addr = 16'h0004; dm_wdata = 16'h1234; dm_size = 2'b00;
      e = '{1, 16'h0000, 0, 0}; sb_q.push_back(e);
      e = '{0, 16'h1234, 1, 0}; sb_q.push_back(e);
      n = 0; phase = 0; ack_n = 0; done = 1'b0; drop_dm = 1'b0;
      while (!done && n < 40) begin
         @(negedge clk);
         if (!if_ack) chk("prio_stall_if", stall_if, 1);
         if (mem_req && phase == 0) begin
            chk("prio_first_we", mem_we, 1);
            chk("prio_first_be", mem_be, 2'b11);
            chk("prio_first_addr", mem_addr, 15'h0002);
            phase = 1;
         end
         if (dm_ack) begin
            ack_n = n; drop_dm = 1'b1; phase = 2;
         end
         if (mem_req && phase == 2) begin
            chk("prio_fetch_we", mem_we, 0);
            chk("prio_fetch_gap", n - ack_n, 2);
            phase = 3;
         end
         if (if_ack) done = 1'b1;
         @(posedge clk); #1;
         n++;
         if (drop_dm) begin dm_wr = 1'b0; drop_dm = 1'b0; end
      end
      chk("prio_done", {done, phase[1:0]}, 3'b111);
      if_req = 1'b0;

      // Timeout: memory never answers a word load.
      @(posedge clk); #1;
      mem_en = 1'b0;
      dm_rd = 1'b1; dm_addr = 16'h0010; dm_size = 2'b00;
      e = '{1, 16'h0000, 1, 1}; sb_q.push_back(e);
      n = 0; hi = 0; done = 1'b0;
      while (!done && n < 60) begin
         @(negedge clk);
         if (mem_req) hi++;
         if (dm_ack) done = 1'b1;
         else begin @(posedge clk); n++; end
      end
      chk("to_ack_seen", done, 1);
      chk("to_req_cycles", hi, TO);
      @(posedge clk); #1;
      drop_all();
      repeat (4) @(posedge clk);
      #1;
      chk("to_err_sticky", err, 1);
      chk("to_mem_req_low", mem_req, 0);

      // Reset while a data access is outstanding.
      dm_rd = 1'b1; dm_addr = 16'h0012; dm_size = 2'b00;
      n = 0;
      while (!mem_req && n < 10) begin @(negedge clk); n++; end
      chk("ra_mem_req_up", mem_req, 1);
      #2;
      rst_n = 1'b0;
      dm_rd = 1'b0;
      #1;
      chk("ra_mem_req_async", mem_req, 0);
      chk("ra_outputs", {if_ack, dm_ack, mem_we, mem_be, err}, 0);
      chk("ra_bus", {mem_addr, mem_wdata, if_rdata, dm_rdata}, 0);
      sb_q.delete();
      mem_en = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      run_vec(100, vecs[0]);

      for (int i = N_OK; i < N_VEC; i++) run_vec(i, vecs[i]);

      repeat (3) @(posedge clk);
      chk("sb_drained", sb_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
